fpu_int2fp: RTL and testbench
=============================

FPU_INT2FP -- requirements
Module: fpu_int2fp

Interface
REQ-001 Parameter: BIAS, default 31, exponent bias of the FPU operand format; legal range 0..31.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 int_in  input  32  two's-complement signed integer to convert.
REQ-005 in_valid  input  1  int_in valid.
REQ-006 in_ready  output  1  block can accept a new integer.
REQ-007 fp_out  output  32  converted operand in FPU format, ready to drive op_A_in/op_B_in.
REQ-008 status_out  output  4  [3] round carry into exponent, [2] sign, [1] zero, [0] inexact.
REQ-009 out_valid  output  1  fp_out/status_out valid.
REQ-010 out_ready  input  1  consumer accepts fp_out.

Function
REQ-011 Format: bit 31 sign; [30:25] exponent E; [24:0] fraction M; value = (-1)^s * 1.M * 2^(E-BIAS); zero = 0x00000000 only.
REQ-012 FSM states: IDLE, NORM, ROUND, DONE; reset state IDLE.
REQ-013 in_ready = 1 only in IDLE; capture on rising edge with in_valid && in_ready.
REQ-014 At capture: sign <= int_in[31]; mag <= |int_in| as 32-bit unsigned (0x80000000 -> mag 0x80000000); exp counter <= BIAS+31.
REQ-015 Capture with int_in == 0: go directly to DONE; fp_out = 0x00000000, status_out = 4'b0010.
REQ-016 Capture with nonzero int_in: go to NORM.
REQ-017 NORM, per cycle: if mag[31] = 1 go to ROUND; else mag <= mag << 1, exp <= exp - 1, stay in NORM.
REQ-018 ROUND, one cycle: M = mag[30:6], guard = mag[5], sticky = |mag[4:0].
REQ-019 Rounding is round-to-nearest-even: round up iff guard && (sticky || mag[6]).
REQ-020 Round up with M = all ones: M <= 0, E <= exp + 1, status[3] = 1; otherwise status[3] = 0.
REQ-021 status[0] = guard | sticky; status[2] = sign; status[1] = 0 for nonzero input.
REQ-022 ROUND -> DONE; fp_out/status_out registered on this edge.
REQ-023 Latency, counted in rising edges after the capture edge to out_valid = 1: zero input 0 (out_valid high right after the capture edge); nonzero input lz+2, where lz = leading zeros of mag at capture (0..31).
REQ-024 E never exceeds BIAS+31 (<= 62); E = 63 is never produced.
REQ-025 DONE: out_valid = 1; fp_out/status_out held stable while out_ready = 0.
REQ-026 DONE with out_ready = 1: transfer on that edge; next state IDLE; out_valid <= 0.
REQ-027 Throughput: one conversion per handshake; in_ready = 0 in NORM/ROUND/DONE; in_valid is ignored there and no input is queued.
REQ-028 fp_out/status_out keep the last result after transfer until the next DONE.

Reset
REQ-029 reset low, at any time including mid-conversion: state IDLE; fp_out = 0; status_out = 0; out_valid = 0; in_ready = 1 after release; in-flight conversion discarded.
REQ-030 No output is produced for an operand whose conversion was aborted by reset.

Verification
REQ-031 int_in=1 -> fp_out=0x3E000000, status=4'b0000, out_valid 33 edges after capture.
REQ-032 int_in=0x80000000 -> fp_out=0xFC000000, status=4'b0100, latency 2 edges.
REQ-033 int_in=0x7FFFFFFF -> fp_out=0x7C000000, status=4'b1001 (carry + inexact), latency 3 edges.
REQ-034 Tie cases: 0x40000010 -> 0x7A000000, status 4'b0001 (round down to even); 0x40000030 -> 0x7A000001, status 4'b0001 (round up to even).
REQ-035 int_in=0 with out_ready=0 for 5 cycles -> out_valid=1 right after the capture edge; fp_out=0, status 4'b0010 held stable for the 5 cycles; in_ready=0 until the transfer edge.
REQ-036 Reset asserted during NORM of int_in=1 -> all outputs 0 immediately; after release, int_in=-1 -> fp_out=0xBE000000, status 4'b0100.

Source files
------------

// File: rtl/fpu_int2fp_if.sv
// Handshake bundle between an integer producer and the int-to-float converter.
//
// Valid/ready rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds its data and valid
// stable until that edge, and ready never depends combinationally on valid.
interface fpu_int2fp_if;
  logic [31:0] int_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output int_in, in_valid, out_ready,
    input  in_ready, fp_out, status_out, out_valid
  );

  // Converter side
  modport slave (
    input  int_in, in_valid, out_ready,
    output in_ready, fp_out, status_out, out_valid
  );
endinterface

// File: rtl/fpu_int2fp.sv
// Multi-cycle signed 32-bit integer to FPU operand converter.
// Operand format: [31] sign, [30:25] biased exponent, [24:0] fraction with a
// hidden leading one; 0x00000000 is the only encoding of zero.
// The magnitude is normalised one bit per cycle, then rounded to nearest-even
// in a single cycle. One conversion is in flight at a time.
module fpu_int2fp #(
  parameter int unsigned BIAS = 31
) (
  input  logic              clock,
  input  logic              reset,
  fpu_int2fp_if.slave       bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Exponent of a magnitude whose leading one sits at bit 31; at most 62, so
  // the all-ones exponent is never produced.
  localparam logic [5:0] EXP_TOP = 6'(BIAS + 31);

  state_t      state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [5:0]  exp_q;
  logic [31:0] fp_q;
  logic [3:0]  status_q;
  logic        in_ready_q;
  logic        out_valid_q;

  logic [31:0] abs_in;
  logic [24:0] frac_trunc;
  logic        guard_b;
  logic        sticky_b;
  logic        round_up;
  logic        frac_ovf;
  logic [24:0] frac_rnd;
  logic [5:0]  exp_rnd;

  // Two's-complement magnitude; 0x80000000 maps onto itself as unsigned.
  assign abs_in = bus.int_in[31] ? (~bus.int_in + 32'd1) : bus.int_in;

  // Round-to-nearest-even of the normalised magnitude (leading one at bit 31).
  always_comb begin
    frac_trunc = mag_q[30:6];
    guard_b    = mag_q[5];
    sticky_b   = |mag_q[4:0];
    round_up   = guard_b & (sticky_b | mag_q[6]);
    frac_ovf   = round_up & (&frac_trunc);
    // On overflow the fraction wraps to zero and the exponent takes the carry.
    frac_rnd   = frac_trunc + {24'd0, round_up};
    exp_rnd    = exp_q + {5'd0, frac_ovf};
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 6'd0;
      fp_q        <= 32'd0;
      status_q    <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sign_q     <= bus.int_in[31];
            mag_q      <= abs_in;
            exp_q      <= EXP_TOP;
            in_ready_q <= 1'b0;
            if (bus.int_in == 32'd0) begin
              // Zero has no leading one to find; publish it immediately.
              fp_q        <= 32'd0;
              status_q    <= 4'b0010;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[31]) begin
            state_q <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 6'd1;
          end
        end
        ROUND: begin
          fp_q        <= {sign_q, exp_rnd, frac_rnd};
          status_q    <= {frac_ovf, sign_q, 1'b0, guard_b | sticky_b};
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Result stays put until the consumer takes it; fp/status are kept
          // afterwards as the last result.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.fp_out     = fp_q;
  assign bus.status_out = status_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fpu_int2fp.sv
// Bench for fpu_int2fp: directed corner values, a held zero result,
// back-to-back and randomized conversions against an arithmetic reference,
// and reset during an in-flight conversion.
module tb_fpu_int2fp;

  localparam int unsigned BIAS = 31;

  logic       clock;
  logic       rst_n;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_bad;
  logic [35:0] exp_q[$];

  fpu_int2fp_if bus();

  fpu_int2fp #(.BIAS(BIAS)) dut (
    .clock   (clock),
    .reset   (rst_n),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value = (-1)^s * 1.M * 2^(E-BIAS), rounded to nearest-even,
  // latency = leading zeros of the magnitude + 2 (0 for zero).
  task automatic ref_model(input logic [31:0] x, output logic [31:0] fp,
                           output logic [3:0] st, output int lat);
    longint v, mag, frac, rem, half, m;
    int p, sh, e;
    bit s, carry, inexact;
    v = longint'($signed(x));
    s = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) begin
      fp = 32'd0; st = 4'b0010; lat = 0;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (mag >= (longint'(1) << i)) p = i;
    frac = mag - (longint'(1) << p);
    inexact = 1'b0;
    if (p >= 25) begin
      sh = p - 25;
      m = frac >> sh;
      rem = frac - (m << sh);
      half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
      inexact = (rem != 0);
      if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 1;
    end else begin
      m = frac << (25 - p);
    end
    e = int'(BIAS) + p;
    carry = 1'b0;
    if (m == (longint'(1) << 25)) begin
      m = 0; e = e + 1; carry = 1'b1;
    end
    fp = {s, e[5:0], m[24:0]};
    st = {carry, s, 1'b0, inexact};
    lat = (31 - p) + 2;
  endtask

  // Driver: one full conversion. Returns what was observed; checks are done
  // by the calling test. noise scribbles on in_valid/int_in while busy.
  task automatic drive_conv(input logic [31:0] x, input int hold, input bit noise,
                            output logic [31:0] fp, output logic [3:0] st,
                            output int lat, output int ready_busy,
                            output int unstable, output logic [31:0] fp_after,
                            output logic ov_after, output logic ir_after);
    int cnt;
    int wt;
    ready_busy = 0;
    unstable = 0;
    lat = -1;
    @(negedge clock);
    wt = 0;
    while (!bus.in_ready && wt < 100) begin
      @(negedge clock);
      wt++;
    end
    bus.int_in = x;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    cnt = 0;
    while (!bus.out_valid && cnt < 100) begin
      if (bus.in_ready) ready_busy++;
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.int_in = $urandom;
      end
      @(posedge clock);
      cnt++;
      @(negedge clock);
    end
    if (bus.out_valid) lat = cnt;
    fp = bus.fp_out;
    st = bus.status_out;
    for (int i = 0; i < hold; i++) begin
      if (bus.in_ready) ready_busy++;
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.int_in = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
      if (!bus.out_valid || bus.fp_out !== fp || bus.status_out !== st) unstable++;
    end
    if (bus.in_ready) ready_busy++;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    fp_after = bus.fp_out;
    ov_after = bus.out_valid;
    ir_after = bus.in_ready;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (bus.fp_out !== 32'd0) begin
      n_bad++; $display("FAIL reset_fp got %h want 00000000", bus.fp_out);
    end
    n_cmp++;
    if (bus.status_out !== 4'd0) begin
      n_bad++; $display("FAIL reset_status got %b want 0000", bus.status_out);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_bad++; $display("FAIL reset_state got %0d want 0 (IDLE)", state_dbg);
    end
  endtask

  // Shared body of the conversion tests is deliberately inline per test.
  task automatic test_directed();
    logic [31:0] vec[8];
    logic [31:0] fp, efp, fpa;
    logic [3:0]  st, est;
    logic [35:0] e;
    logic ova, ira;
    int lat, elat, rb, us;
    vec = '{32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4000_0010,
            32'h4000_0030, 32'hFFFF_FFFF, 32'h0200_0003, 32'hFE00_0041};
    foreach (vec[k]) begin
      ref_model(vec[k], efp, est, elat);
      exp_q.push_back({est, efp});
      drive_conv(vec[k], 1, 1'b0, fp, st, lat, rb, us, fpa, ova, ira);
      e = exp_q.pop_front();
      n_cmp++;
      if (fp !== e[31:0]) begin
        n_bad++; $display("FAIL dir_fp x=%h got %h want %h", vec[k], fp, e[31:0]);
      end
      n_cmp++;
      if (st !== e[35:32]) begin
        n_bad++; $display("FAIL dir_status x=%h got %b want %b", vec[k], st, e[35:32]);
      end
      n_cmp++;
      if (lat !== elat) begin
        n_bad++; $display("FAIL dir_latency x=%h got %0d want %0d", vec[k], lat, elat);
      end
      n_cmp++;
      if (rb !== 0 || us !== 0) begin
        n_bad++; $display("FAIL dir_busy x=%h ready_busy=%0d unstable=%0d want 0/0", vec[k], rb, us);
      end
      n_cmp++;
      if (fpa !== e[31:0] || ova !== 1'b0 || ira !== 1'b1) begin
        n_bad++; $display("FAIL dir_after x=%h fp=%h ov=%b ir=%b want %h 0 1", vec[k], fpa, ova, ira, e[31:0]);
      end
    end
  endtask

  task automatic test_zero_hold();
    logic [31:0] fp, fpa;
    logic [3:0]  st;
    logic ova, ira;
    int lat, rb, us;
    drive_conv(32'd0, 5, 1'b0, fp, st, lat, rb, us, fpa, ova, ira);
    n_cmp++;
    if (fp !== 32'd0 || st !== 4'b0010) begin
      n_bad++; $display("FAIL zero_result got %h/%b want 00000000/0010", fp, st);
    end
    n_cmp++;
    if (lat !== 0) begin
      n_bad++; $display("FAIL zero_latency got %0d want 0", lat);
    end
    n_cmp++;
    if (us !== 0) begin
      n_bad++; $display("FAIL zero_hold_stable got %0d unstable cycles want 0", us);
    end
    n_cmp++;
    if (rb !== 0) begin
      n_bad++; $display("FAIL zero_in_ready_busy got %0d want 0", rb);
    end
    n_cmp++;
    if (ova !== 1'b0 || ira !== 1'b1 || fpa !== 32'd0) begin
      n_bad++; $display("FAIL zero_after ov=%b ir=%b fp=%h want 0 1 00000000", ova, ira, fpa);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, fp, efp, fpa;
    logic [3:0]  st, est;
    logic [35:0] e;
    logic ova, ira;
    int lat, elat, rb, us;
    for (int k = 0; k < 6; k++) begin
      x = $urandom;
      x = x >> $urandom_range(0, 31);
      ref_model(x, efp, est, elat);
      exp_q.push_back({est, efp});
      drive_conv(x, 0, 1'b1, fp, st, lat, rb, us, fpa, ova, ira);
      e = exp_q.pop_front();
      n_cmp++;
      if ({st, fp} !== e || lat !== elat || rb !== 0) begin
        n_bad++;
        $display("FAIL b2b x=%h got %b/%h lat %0d rb %0d want %b/%h lat %0d rb 0",
                 x, st, fp, lat, rb, e[35:32], e[31:0], elat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, fp, efp, fpa;
    logic [3:0]  st, est;
    logic [35:0] e;
    logic ova, ira;
    int lat, elat, rb, us, hold;
    for (int k = 0; k < 60; k++) begin
      x = $urandom;
      x = x >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 15) == 0) x = 32'd0;
      hold = $urandom_range(0, 3);
      ref_model(x, efp, est, elat);
      exp_q.push_back({est, efp});
      drive_conv(x, hold, 1'($urandom_range(0, 1)), fp, st, lat, rb, us, fpa, ova, ira);
      e = exp_q.pop_front();
      n_cmp++;
      if (fp !== e[31:0] || st !== e[35:32]) begin
        n_bad++; $display("FAIL rnd_result x=%h got %h/%b want %h/%b", x, fp, st, e[31:0], e[35:32]);
      end
      n_cmp++;
      if (lat !== elat) begin
        n_bad++; $display("FAIL rnd_latency x=%h got %0d want %0d", x, lat, elat);
      end
      n_cmp++;
      if (rb !== 0 || us !== 0 || ova !== 1'b0 || ira !== 1'b1 || fpa !== e[31:0]) begin
        n_bad++;
        $display("FAIL rnd_handshake x=%h rb=%0d us=%0d ov=%b ir=%b fp_after=%h want 0 0 0 1 %h",
                 x, rb, us, ova, ira, fpa, e[31:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] fp, fpa;
    logic [3:0]  st;
    logic ova, ira;
    int lat, rb, us, spurious;
    @(negedge clock);
    bus.int_in = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.fp_out !== 32'd0 || bus.status_out !== 4'd0 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs fp=%h st=%b ov=%b want 00000000 0000 0",
               bus.fp_out, bus.status_out, bus.out_valid);
    end
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL midreset_in_ready got %b want 1", bus.in_ready);
    end
    spurious = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_bad++; $display("FAIL midreset_no_output got %0d valid cycles want 0", spurious);
    end
    drive_conv(32'hFFFF_FFFF, 1, 1'b0, fp, st, lat, rb, us, fpa, ova, ira);
    n_cmp++;
    if (fp !== 32'hBE00_0000 || st !== 4'b0100 || lat !== 33) begin
      n_bad++; $display("FAIL midreset_next got %h/%b lat %0d want be000000/0100 lat 33", fp, st, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.int_in = 32'd0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    test_reset();
    test_directed();
    test_zero_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
